fp_burst_scheduler: RTL and testbench
=====================================

Name: fp_burst_scheduler

Overview:
- Packet-level scheduler in front of the per-queue buffers of the relational cache.
- Picks the highest-priority non-empty queue by fixed priority, then locks the grant and drains that queue beat-by-beat over a valid/ready output until end-of-packet or a burst cap.
- Only then re-arbitrates.
- Sequences the queue-pop side so the downstream datapath sees whole packets from one queue at a time.

Parameters:
- NUMBER_OF_QUEUES, 4, number of input queues (>=2).
- PRIORITY_SIZE, 4, width of each per-queue priority.
- MAX_BURST, 16, maximum beats served per grant (>=1).
- AGING_THRESHOLD, 8, lost arbitrations before a waiting queue is boosted (FP_AGING_EN only).

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- priorities  input  [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0]  user priority per queue; higher value wins.
- empty  input  [NUMBER_OF_QUEUES-1:0]  queue has no beat at its head.
- head_last  input  [NUMBER_OF_QUEUES-1:0]  head beat of queue is last of its packet.
- out_ready  input  1  downstream accepts a beat.
- out_valid  output  1  beat from the granted queue is presented.
- out_last  output  1  presented beat closes the grant (head_last or burst cap).
- out_queue_id  output  $clog2(NUMBER_OF_QUEUES)  granted queue id.
- pop  output  [NUMBER_OF_QUEUES-1:0]  one-hot pop to the queue buffers.
- busy  output  1  grant held (state BURST).

Behaviour:
- Reset values: state=IDLE, out_valid=0, out_last=0, out_queue_id=0, pop=0, busy=0, beat_count=0, aging counters=0.
- Reset is honoured at any cycle. Mid-burst it abandons the grant with no pop.
- Eligibility: a queue is eligible iff !empty. Priority 0 is still eligible.
- Winner: maximum priority among eligible queues. Ties go to the lowest index.
- State IDLE:
  - If any queue is eligible, register winner into out_queue_id, clear beat_count, go to BURST.
  - Otherwise stay in IDLE.
  - No pop is issued in IDLE. Arbitration-to-first-beat latency is 1 cycle.
- State BURST:
  - out_valid = !empty[out_queue_id].
  - out_last = out_valid & (head_last[out_queue_id] | beat_count==MAX_BURST-1).
  - pop[out_queue_id] = out_valid & out_ready. All other pop bits are 0.
  - Each pop increments beat_count.
- Release: a pop with out_last=1 returns the state to IDLE next cycle. The next grant starts one cycle after that, so there is one dead cycle between grants.
- Starvation inside a burst: if the granted queue goes empty mid-packet, out_valid drops and the grant is held. Higher-priority arrivals do not preempt.
- Combinational paths: out_valid and out_last depend combinationally on empty and head_last. out_queue_id, busy and the state are registered.
- beat_count is $clog2(MAX_BURST+1) bits and never wraps. It is cleared on each new grant.
- Priorities and empty are sampled only in IDLE. Changes during BURST have no effect until the next arbitration.

Optional Feature:
- Macro FP_AGING_EN.
- Defined:
  - Each queue has a saturating wait counter of $clog2(AGING_THRESHOLD+1) bits.
  - The counter increments on each IDLE->BURST arbitration that the queue loses while non-empty. It clears when the queue wins or is empty.
  - While the counter equals AGING_THRESHOLD, the queue's effective priority is all-ones. Ties still go to the lowest index.
- Undefined: no counters; pure fixed priority.

Decomposition:
- Package fp_sched_pkg:
  - queue_id_t and priority_t typedefs, derived from package-level NUMBER_OF_QUEUES and PRIORITY_SIZE defaults.
  - state enum {IDLE, BURST}.
- One sub-module, fp_priority_select: combinational winner/any_eligible over the effective priorities, with lowest-index tie-break. It is instantiated once.

Test Plan:
- Priorities {q3..q0}={2,9,9,1}, all non-empty, out_ready=1 -> q1 granted (tie with q2 goes to the lower index). First out_valid one cycle after leaving IDLE.
- q0 priority 5 only non-empty, 3-beat packet (head_last on beat 3), out_ready=1 -> exactly 3 pops on pop[0], out_last on beat 3, IDLE for 1 cycle after.
- MAX_BURST=4, q2 has a 10-beat packet -> out_last at beat 4, re-arbitrate, q2 regranted, next 4 beats.
- Granted q1 goes empty after beat 2; q3 (priority 15) arrives -> out_valid=0 and the grant stays on q1 with no pops. q1 refills and finishes before q3 is served.
- out_ready toggles 1,0,0,1 during BURST -> pop only in ready cycles, beat_count advances only on pops.
- Reset asserted mid-burst -> next cycle all outputs at reset values, pop=0.
- FP_AGING_EN, AGING_THRESHOLD=2: q0 priority 0, q3 priority 15 with back-to-back 1-beat packets -> q0 wins the third arbitration.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared types for the fixed-priority burst scheduler.
package fp_sched_pkg;

    localparam int unsigned NumQueuesDefault    = 4;
    localparam int unsigned PrioritySizeDefault = 4;

    typedef logic [$clog2(NumQueuesDefault)-1:0] queue_id_t;
    typedef logic [PrioritySizeDefault-1:0]      priority_t;

    // IDLE arbitrates, BURST holds the grant until the packet or burst cap closes.
    typedef enum logic {
        StIdle,
        StBurst
    } state_t;

endpackage

// File: rtl/fp_priority_select.sv
// Combinational max-priority selector; ties resolve to the lowest index.
module fp_priority_select
    import fp_sched_pkg::*;
#(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned PRIORITY_SIZE    = 4,
    localparam int unsigned QidWidth        = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic [NUMBER_OF_QUEUES-1:0]                    eligible_i,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0] priorities_i,
    output logic [QidWidth-1:0]                            winner_o,
    output logic                                           any_eligible_o
);

    logic [PRIORITY_SIZE-1:0] best_prio;
    logic                     found;

    // Linear scan; strict greater-than keeps the earlier (lower) index on ties.
    always_comb begin
        best_prio = '0;
        found     = 1'b0;
        winner_o  = '0;
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (eligible_i[i] && (!found || priorities_i[i] > best_prio)) begin
                found     = 1'b1;
                best_prio = priorities_i[i];
                winner_o  = QidWidth'(i);
            end
        end
        any_eligible_o = found;
    end

endmodule

// File: rtl/fp_burst_scheduler.sv
// Packet-level burst scheduler: fixed-priority grant, held until end-of-packet or burst cap.
// Optional FP_AGING_EN: queues that keep losing arbitration get boosted to top priority.
module fp_burst_scheduler
    import fp_sched_pkg::*;
#(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned PRIORITY_SIZE    = 4,
    parameter int unsigned MAX_BURST        = 16,
    parameter int unsigned AGING_THRESHOLD  = 8,
    localparam int unsigned QidWidth        = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0] priorities,
    input  logic [NUMBER_OF_QUEUES-1:0]                    empty,
    input  logic [NUMBER_OF_QUEUES-1:0]                    head_last,
    input  logic                                           out_ready,
    output logic                                           out_valid,
    output logic                                           out_last,
    output logic [QidWidth-1:0]                            out_queue_id,
    output logic [NUMBER_OF_QUEUES-1:0]                    pop,
    output logic                                           busy
);

    localparam int unsigned BeatWidth = $clog2(MAX_BURST + 1);
    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(MAX_BURST - 1);

    state_t                 state_q, state_d;
    logic [QidWidth-1:0]    qid_q, qid_d;
    logic [BeatWidth-1:0]   beat_q, beat_d;

    logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0] eff_prio;
    logic [QidWidth-1:0]    winner;
    logic                   any_eligible;
    logic                   arbitrate;

    assign arbitrate = (state_q == StIdle) && any_eligible;

`ifdef FP_AGING_EN
    localparam int unsigned AgeWidth = $clog2(AGING_THRESHOLD + 1);
    localparam logic [AgeWidth-1:0] AgeMax = AgeWidth'(AGING_THRESHOLD);

    logic [NUMBER_OF_QUEUES-1:0][AgeWidth-1:0] age_q, age_d;

    // Saturating per-queue wait counters; a saturated queue competes at all-ones priority.
    always_comb begin
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            age_d[i]    = age_q[i];
            eff_prio[i] = (age_q[i] == AgeMax) ? '1 : priorities[i];
            if (empty[i]) begin
                age_d[i] = '0;
            end else if (arbitrate) begin
                if (winner == QidWidth'(i)) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AgeMax) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign eff_prio = priorities;
`endif

    fp_priority_select #(
        .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
        .PRIORITY_SIZE    (PRIORITY_SIZE)
    ) u_select (
        .eligible_i     (~empty),
        .priorities_i   (eff_prio),
        .winner_o       (winner),
        .any_eligible_o (any_eligible)
    );

    // Output handshake and next-state; reset suppresses any pop in the abandoning cycle.
    always_comb begin
        state_d   = state_q;
        qid_d     = qid_q;
        beat_d    = beat_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        pop       = '0;
        unique case (state_q)
            StIdle: begin
                if (any_eligible) begin
                    state_d = StBurst;
                    qid_d   = winner;
                    beat_d  = '0;
                end
            end
            StBurst: begin
                out_valid  = !empty[qid_q] && !reset;
                out_last   = out_valid && (head_last[qid_q] || beat_q == LastBeat);
                pop[qid_q] = out_valid && out_ready;
                if (pop[qid_q]) begin
                    beat_d = beat_q + 1'b1;
                    if (out_last) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            qid_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            qid_q   <= qid_d;
            beat_q  <= beat_d;
        end
    end

    assign out_queue_id = qid_q;
    assign busy         = (state_q == StBurst);

endmodule

// File: tb/tb_fp_burst_scheduler.sv
// Self-checking bench for fp_burst_scheduler (MAX_BURST=4, AGING_THRESHOLD=2).
// Queue buffers are modelled as beat counts with a fixed packet length per queue.
module tb_fp_burst_scheduler;

    localparam int NQ = 4;
    localparam int PS = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [1:0] qid;
        logic       last;
    } beat_t;

    logic                   clock;
    logic                   reset;
    logic [NQ-1:0][PS-1:0]  priorities;
    logic [NQ-1:0]          empty;
    logic [NQ-1:0]          head_last;
    logic                   out_ready;
    logic                   out_valid;
    logic                   out_last;
    logic [1:0]             out_queue_id;
    logic [NQ-1:0]          pop;
    logic                   busy;

    fp_burst_scheduler #(
        .NUMBER_OF_QUEUES (NQ),
        .PRIORITY_SIZE    (PS),
        .MAX_BURST        (MB),
        .AGING_THRESHOLD  (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .priorities   (priorities),
        .empty        (empty),
        .head_last    (head_last),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_queue_id (out_queue_id),
        .pop          (pop),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int avail [NQ];
    int pos   [NQ];
    int plen  [NQ];

    beat_t exp_q[$];
    beat_t got_q[$];

    logic          s_valid, s_last, s_busy;
    logic [NQ-1:0] s_pop;
    logic [1:0]    s_qid;

    task automatic apply();
        for (int i = 0; i < NQ; i++) begin
            empty[i]     = (avail[i] == 0);
            head_last[i] = (pos[i] == plen[i] - 1);
        end
    endtask

    // One clock: sample at negedge, then advance the queue model by the pops just taken.
    task automatic tick();
        @(negedge clock);
        s_valid = out_valid;
        s_last  = out_last;
        s_pop   = pop;
        s_busy  = busy;
        s_qid   = out_queue_id;
        if (out_valid && out_ready) got_q.push_back('{qid: out_queue_id, last: out_last});
        @(posedge clock);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (s_pop[i] && avail[i] > 0) begin
                avail[i]--;
                pos[i] = (pos[i] + 1 == plen[i]) ? 0 : pos[i] + 1;
            end
        end
        apply();
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && got_q.size() < n; c++) tick();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        out_ready  = 1'b0;
        priorities = '0;
        for (int i = 0; i < NQ; i++) begin
            avail[i] = 0;
            pos[i]   = 0;
            plen[i]  = 1;
        end
        apply();
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        tick();
        checks++;
        if ({s_valid, s_last, s_busy, s_qid, s_pop} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b last=%0b busy=%0b qid=%0d pop=%b, required all 0",
                     s_valid, s_last, s_busy, s_qid, s_pop);
        end
        reset = 1'b0;
    endtask

    task automatic test_tie_grant();
        beat_t e, g;
        do_reset();
        priorities[3] = 2; priorities[2] = 9; priorities[1] = 9; priorities[0] = 1;
        for (int i = 0; i < NQ; i++) avail[i] = 1;
        out_ready = 1'b1;
        apply();
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_arb_cycle: got busy=%0b valid=%0b, required 0 0", s_busy, s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_qid !== 2'd1) begin
            errors++;
            $display("FAIL tie_first_beat: got valid=%0b qid=%0d, required 1 q1", s_valid, s_qid);
        end
        exp_q.push_back('{qid: 2'd1, last: 1'b1});
        exp_q.push_back('{qid: 2'd2, last: 1'b1});
        exp_q.push_back('{qid: 2'd3, last: 1'b1});
        exp_q.push_back('{qid: 2'd0, last: 1'b1});
        run_until(4, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL tie_order: got no beat, required q%0d last=%0b", e.qid, e.last);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL tie_order: got q%0d last=%0b, required q%0d last=%0b",
                             g.qid, g.last, e.qid, e.last);
                end
            end
        end
    endtask

    task automatic test_packet();
        beat_t e, g;
        logic [5:0] exp_busy  = 6'b101110;
        logic [5:0] exp_valid = 6'b101110;
        logic [5:0] exp_last  = 6'b001000;
        int npop = 0;
        do_reset();
        priorities[0] = 5;
        plen[0]  = 3;
        avail[0] = 6;
        out_ready = 1'b1;
        apply();
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c < 5 && s_pop[0]) npop++;
            checks++;
            if (s_busy !== exp_busy[c] || s_valid !== exp_valid[c] || s_last !== exp_last[c]) begin
                errors++;
                $display("FAIL packet_cycle%0d: got busy=%0b valid=%0b last=%0b, required %0b %0b %0b",
                         c, s_busy, s_valid, s_last, exp_busy[c], exp_valid[c], exp_last[c]);
            end
        end
        checks++;
        if (npop != 3) begin
            errors++;
            $display("FAIL packet_pops: got %0d pops on q0, required 3", npop);
        end
        for (int b = 0; b < 6; b++) exp_q.push_back('{qid: 2'd0, last: (b % 3 == 2)});
        run_until(6, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL packet_beats: got no beat, required q%0d last=%0b", e.qid, e.last);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL packet_beats: got q%0d last=%0b, required q%0d last=%0b",
                             g.qid, g.last, e.qid, e.last);
                end
            end
        end
    endtask

    task automatic test_burst_cap();
        beat_t e, g;
        do_reset();
        priorities[2] = 3;
        plen[2]  = 10;
        avail[2] = 10;
        out_ready = 1'b1;
        apply();
        for (int b = 0; b < 10; b++) exp_q.push_back('{qid: 2'd2, last: (b == 3 || b == 7 || b == 9)});
        run_until(10, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL burst_cap: got no beat, required q%0d last=%0b", e.qid, e.last);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL burst_cap: got q%0d last=%0b, required q%0d last=%0b",
                             g.qid, g.last, e.qid, e.last);
                end
            end
        end
    endtask

    task automatic test_starve();
        beat_t e, g;
        do_reset();
        priorities[1] = 4;
        plen[1]  = 4;
        avail[1] = 2;
        out_ready = 1'b1;
        apply();
        for (int b = 0; b < 4; b++) exp_q.push_back('{qid: 2'd1, last: (b == 3)});
        exp_q.push_back('{qid: 2'd3, last: 1'b1});
        run_until(2, 20);
        priorities[3] = 15;
        avail[3] = 1;
        apply();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (s_valid !== 1'b0 || s_pop !== '0 || s_busy !== 1'b1 || s_qid !== 2'd1) begin
                errors++;
                $display("FAIL starve_hold%0d: got valid=%0b pop=%b busy=%0b qid=%0d, required 0 0000 1 q1",
                         c, s_valid, s_pop, s_busy, s_qid);
            end
        end
        avail[1] = 2;
        apply();
        run_until(5, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL starve_order: got no beat, required q%0d last=%0b", e.qid, e.last);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL starve_order: got q%0d last=%0b, required q%0d last=%0b",
                             g.qid, g.last, e.qid, e.last);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pattern = 8'b10101001; // bit c is out_ready in burst cycle c
        int cnt = 0;
        logic exp_pop, exp_last;
        do_reset();
        priorities[0] = 1;
        plen[0]  = 10;
        avail[0] = 10;
        apply();
        tick();
        for (int c = 0; c < 8; c++) begin
            out_ready = pattern[c];
            exp_pop   = pattern[c];
            exp_last  = (cnt == MB - 1);
            tick();
            checks++;
            if (s_pop !== {3'b000, exp_pop} || s_last !== exp_last || s_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure%0d: got pop=%b last=%0b valid=%0b, required pop[0]=%0b last=%0b valid=1",
                         c, s_pop, s_last, s_valid, exp_pop, exp_last);
            end
            if (exp_pop) cnt++;
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        priorities[2] = 7;
        plen[2]  = 5;
        avail[2] = 5;
        out_ready = 1'b1;
        apply();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (s_pop !== '0 || s_valid !== 1'b0 || s_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pop: got pop=%b valid=%0b last=%0b, required 0", s_pop, s_valid, s_last);
        end
        tick();
        checks++;
        if ({s_valid, s_last, s_busy, s_qid, s_pop} !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: got valid=%0b last=%0b busy=%0b qid=%0d pop=%b, required all 0",
                     s_valid, s_last, s_busy, s_qid, s_pop);
        end
        checks++;
        if (avail[2] != 3) begin
            errors++;
            $display("FAIL reset_mid_beats: got %0d beats left in q2, required 3", avail[2]);
        end
        reset = 1'b0;
    endtask

    task automatic test_aging();
        beat_t e, g;
        do_reset();
        priorities[0] = 0;
        priorities[3] = 15;
        avail[0] = 1;
        avail[3] = 8;
        out_ready = 1'b1;
        apply();
        exp_q.push_back('{qid: 2'd3, last: 1'b1});
        exp_q.push_back('{qid: 2'd3, last: 1'b1});
`ifdef FP_AGING_EN
        exp_q.push_back('{qid: 2'd0, last: 1'b1});
`else
        exp_q.push_back('{qid: 2'd3, last: 1'b1});
`endif
        run_until(3, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++;
                $display("FAIL aging_order: got no beat, required q%0d last=%0b", e.qid, e.last);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL aging_order: got q%0d last=%0b, required q%0d last=%0b",
                             g.qid, g.last, e.qid, e.last);
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        out_ready  = 1'b0;
        priorities = '0;
        empty      = '1;
        head_last  = '0;
        test_reset();
        test_tie_grant();
        test_packet();
        test_burst_cap();
        test_starve();
        test_backpressure();
        test_reset_mid_burst();
        test_aging();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
